// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner: BLANK/SHOW time slots per digit,
// double-buffered display value swapped only at the frame wrap.
module seg7_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic [3:0]  en_mask,
  input  logic        lz_sup,
  output logic [3:0]  nibble,
  input  logic [6:0]  seg7,
  output logic [3:0]  an,
  output logic [7:0]  seg_n,
  output logic        frame_done,
  output logic        pending
);

  localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [CW-1:0] cnt_q;
  logic [15:0] active_q, shadow_q;
  logic [3:0]  active_dp_q, shadow_dp_q;
  logic        pending_q;
  logic [3:0]  an_q;
  logic [7:0]  seg_n_q;
  logic        frame_done_q;

  logic        show_end, blank_end, boundary;
  logic [3:0]  zero, lead_z, supp, an_d;

  always_comb begin
    show_end  = (state_q == SHOW)  && (cnt_q == SHOW_LAST);
    blank_end = (state_q == BLANK) && (cnt_q == BLANK_LAST);
    boundary  = show_end && (idx_q == 2'd3);
    for (int n = 0; n < 4; n++) zero[n] = (active_q[4*n +: 4] == 4'h0);
    // lead_z[n]: digits 3..n all zero; digit 0 is never blanked as a leading zero
    lead_z[3] = zero[3];
    lead_z[2] = lead_z[3] & zero[2];
    lead_z[1] = lead_z[2] & zero[1];
    lead_z[0] = 1'b0;
    supp = ~en_mask | (lead_z & {4{lz_sup}});
    an_d = 4'hF;
    if (state_q == SHOW && !supp[idx_q]) an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= 4'hF;
      seg_n_q      <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        BLANK: begin
          if (blank_end) begin
            state_q <= SHOW;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          if (show_end) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= (idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
          end else cnt_q <= cnt_q + 1'b1;
        end
      endcase

      // A load on the wrap cycle bypasses the shadow entirely
      if (boundary) begin
        if (load) begin
          active_q    <= value;
          active_dp_q <= dp;
        end else if (pending_q) begin
          active_q    <= shadow_q;
          active_dp_q <= shadow_dp_q;
        end
        pending_q <= 1'b0;
      end else if (load) begin
        shadow_q    <= value;
        shadow_dp_q <= dp;
        pending_q   <= 1'b1;
      end

      an_q         <= an_d;
      seg_n_q      <= {~active_dp_q[idx_q], ~seg7};
      frame_done_q <= boundary;
    end
  end

  assign nibble     = active_q[{idx_q, 2'b00} +: 4];
  assign an         = an_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model checked every cycle.
module tb_seg7_scan_ctrl;
  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = CD + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, lz_sup = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0, en_mask = 4'hF;
  logic [3:0]  nibble, an;
  logic [6:0]  seg7;
  logic [7:0]  seg_n;
  logic        frame_done, pending;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .en_mask(en_mask), .lz_sup(lz_sup), .nibble(nibble), .seg7(seg7),
    .an(an), .seg_n(seg_n), .frame_done(frame_done), .pending(pending)
  );

  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
      4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
      4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
      4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
    endcase
  endfunction

  // external hex decoder
  assign seg7 = dec7(nibble);

  // model: p = clock edges since reset release; frame position is p mod FRAME
  int          p;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_fd;
  int          n_chk = 0, n_fail = 0;

  function automatic logic [3:0] exp_an_at(input int q);
    int f, d;
    logic [3:0] one;
    one = 4'b0001;
    f = q % FRAME;
    d = f / SLOT;
    if (f % SLOT < BC) return 4'hF;
    if (!en_mask[d]) return 4'hF;
    if (lz_sup && d > 0 && (m_act >> (4 * d)) == 16'h0) return 4'hF;
    return ~(one << d);
  endfunction

  task automatic model_reset();
    p = 0; m_act = '0; m_sh = '0; m_dp = '0; m_shdp = '0; m_pend = 1'b0;
    e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (p=%0d)", tag, obs, exp, p);
    end
  endtask

  task automatic check_all();
    int dn;
    dn = (p % FRAME) / SLOT;
    chk("an", 16'(an), 16'(e_an));
    chk("seg_n", 16'(seg_n), 16'(e_seg));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
    chk("pending", 16'(pending), 16'(m_pend));
    chk("nibble", 16'(nibble), 16'(m_act[4*dn +: 4]));
    chk("one_anode", 16'($countones(~an) <= 1), 16'd1);
  endtask

  task automatic step();
    int f, d;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      f = p % FRAME;
      d = f / SLOT;
      e_an  = exp_an_at(p);
      e_seg = {~m_dp[d], ~dec7(m_act[4*d +: 4])};
      e_fd  = (f == FRAME - 1);
      if (f == FRAME - 1) begin
        if (load) begin m_act = value; m_dp = dp; end
        else if (m_pend) begin m_act = m_sh; m_dp = m_shdp; end
        m_pend = 1'b0;
      end else if (load) begin
        m_sh = value; m_shdp = dp; m_pend = 1'b1;
      end
      p++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int k);
    for (int i = 0; i < FRAME && (p % FRAME) != k; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    run(3);
    rst = 1'b0;

    do_load(16'h1234, 4'b0101);
    run(95);

    lz_sup = 1'b1;
    do_load(16'h0050, 4'h0);
    run(85);
    do_load(16'h0000, 4'h0);
    run(85);
    lz_sup = 1'b0;

    // two loads in one frame, the later one wins
    wait_phase(12);
    do_load(16'hAAAA, 4'h3);
    run(4);
    do_load(16'hBBBB, 4'hC);
    run(70);

    // load on the wrap cycle goes straight to the display
    wait_phase(FRAME - 1);
    do_load(16'h9C07, 4'hA);
    run(45);

    for (int it = 0; it < 10; it++) begin
      en_mask = (it % 3 == 0) ? 4'hF : 4'($urandom);
      lz_sup  = 1'($urandom);
      wait_phase($urandom_range(0, FRAME - 1));
      do_load(16'($urandom) >> (4 * $urandom_range(0, 3)), 4'($urandom));
      run($urandom_range(10, 40));
      en_mask = 4'($urandom);
      run($urandom_range(10, 60));
    end

    // reset mid-frame during digit 2 SHOW with a load waiting
    en_mask = 4'hF; lz_sup = 1'b0;
    wait_phase(5);
    do_load(16'h5678, 4'hF);
    wait_phase(25);
    chk("pend_before_rst", 16'(pending), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg_n", 16'(seg_n), 16'hFF);
    chk("rst_nibble", 16'(nibble), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_fd", 16'(frame_done), 16'h0);
    model_reset();
    run(2);
    rst = 1'b0;
    run(90);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CLK_DIV    100000   cycles each digit is lit (SHOW phase); legal range >= 2
  BLANK_CYC  1000     cycles all anodes are off before each digit (BLANK phase); legal range >= 2
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk        in   1   single system clock; all logic on its rising edge
  rst        in   1   asynchronous, active-high reset
  value      in   16  four hex digits; [3:0] = digit 0 (rightmost)
  dp         in   4   decimal points, bit n = digit n, active-high
  load       in   1   1-cycle strobe; captures value and dp
  en_mask    in   4   digit enable, bit n = digit n
  lz_sup     in   1   leading-zero suppression enable
  nibble     out  4   hex code of the current digit, sent to the external hex-to-7-segment decoder
  seg7       in   7   decoder output, active-high; [6]=a ... [0]=g
  an         out  4   digit anodes, active-low
  seg_n      out  8   cathodes, active-low; [7]=dp, [6:0]=a..g
  frame_done out  1   1-cycle pulse at frame wrap
  pending    out  1   a captured value is waiting for a frame boundary

Function
REQ-003 The FSM SHALL have exactly two states, BLANK and SHOW, plus a 2-bit digit index idx and a cycle counter.
REQ-004 BLANK SHALL last exactly BLANK_CYC cycles, then go to SHOW with the counter cleared.
REQ-005 SHOW SHALL last exactly CLK_DIV cycles, then go to BLANK with idx incremented mod 4.
REQ-006 One frame SHALL be exactly 4*(CLK_DIV+BLANK_CYC) cycles, independent of en_mask, lz_sup and value.
REQ-007 nibble SHALL be combinational: active[4*idx+3 : 4*idx], where active is the displayed register; nibble therefore changes at the start of BLANK.
REQ-008 seg_n[6:0] SHALL be registered: ~seg7, one cycle of latency.
REQ-009 seg_n[7] SHALL be registered: ~active_dp[idx], one cycle of latency.
REQ-010 an SHALL be registered with the same one-cycle latency.
REQ-011 In BLANK, an SHALL be 4'hF.
REQ-012 In SHOW, an[idx] SHALL be 0 only if the digit is not suppressed; all other an bits SHALL be 1.
REQ-013 Digit n SHALL be suppressed if en_mask[n]=0.
REQ-014 With lz_sup=1, digit n (n=3,2,1) SHALL also be suppressed if active digits 3..n are all 0; digit 0 SHALL never be zero-suppressed.
REQ-015 Only one anode SHALL ever be low at a time.
REQ-016 load=1 SHALL capture value and dp into shadow registers and set pending=1; a later load before the boundary SHALL overwrite the shadow (last load wins).
REQ-017 The frame boundary SHALL be the cycle in which idx wraps 3->0 on the SHOW->BLANK transition.
REQ-018 At the frame boundary, if pending=1, active SHALL take the shadow and pending SHALL clear; frame_done SHALL pulse high for 1 cycle.
REQ-019 If load coincides with the boundary, the new value and dp SHALL go directly to active and pending SHALL stay 0.
REQ-020 en_mask and lz_sup SHALL take effect immediately; they are not shadowed.
REQ-021 Counter widths SHALL be sized from the parameters with no overflow; wrap SHALL be by explicit compare, not by natural overflow.

Reset
REQ-022 While rst=1, the block SHALL hold: state=BLANK, idx=0, counter=0, active=0, active_dp=0, shadow=0, pending=0.
REQ-023 While rst=1, outputs SHALL be: an=4'hF, seg_n=8'hFF, nibble=4'h0, frame_done=0.
REQ-024 rst asserted mid-frame SHALL abort immediately, discarding any pending load.
REQ-025 After release, the first SHOW SHALL begin BLANK_CYC cycles after the first clk edge.

Verification (CLK_DIV=8, BLANK_CYC=2, frame = 40 cycles)
REQ-026 Reset release, load value=16'h1234, en_mask=4'hF -> from the next frame, an cycles through E,D,B,7, each low for 8 cycles, separated by 2 cycles of F.
REQ-026 (cont.) During those digits, seg_n[6:0] = ~decoder(4,3,2,1) respectively.
REQ-027 value=16'h0050, lz_sup=1 -> digit 3 and digit 2 anodes stay high in their slots; digits 1 and 0 lit; frame length still 40.
REQ-028 value=16'h0000, lz_sup=1 -> only digit 0 lit, showing 0.
REQ-029 load 16'hAAAA mid-frame, then load 16'hBBBB 5 cycles later -> pending=1 until the wrap; the next frame shows BBBB; frame_done pulses once.
REQ-030 load exactly on the boundary cycle -> the new value is shown in the next frame; pending never rises.
REQ-031 rst pulse during SHOW of digit 2 with a load pending -> an=F and seg_n=FF immediately; after release, digits show 0000; pending=0.
